// File: rtl/seq_detect_param_if.sv
// Serial pattern-detector bus: qualified bit stream in, registered match pulse out.
// Optional SEQ_MATCH_CNT_EN adds the match counter and its clear.
interface seq_detect_param_if #(
    parameter int unsigned CNT_W = 8
);
    logic             data_valid;
    logic             data_in;
    logic             overlap_en;
    logic             data_out;
`ifdef SEQ_MATCH_CNT_EN
    logic             cnt_clr;
    logic [CNT_W-1:0] match_cnt;

    modport master (output data_valid, data_in, overlap_en, cnt_clr,
                    input  data_out, match_cnt);
    modport slave  (input  data_valid, data_in, overlap_en, cnt_clr,
                    output data_out, match_cnt);
`else
    modport master (output data_valid, data_in, overlap_en,
                    input  data_out);
    modport slave  (input  data_valid, data_in, overlap_en,
                    output data_out);
`endif
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with overlap/non-overlap modes and stall on !data_valid.
// Define SEQ_MATCH_CNT_EN to add a saturating match counter (match_cnt) with clear (cnt_clr).
module seq_detect_param #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int unsigned      CNT_W   = 8
) (
    input logic               clk,
    input logic               reset,
    seq_detect_param_if.slave bus
);
    localparam int unsigned      FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d, hist_n;
    logic [FILL_W-1:0] fill_q, fill_d, fill_n;
    logic              out_q, out_d;
    logic              hit;

    // fill guards against zeroed history bits forming a false early match
    always_comb begin
        hist_n = {hist_q[PAT_W-2:0], bus.data_in};
        fill_n = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);
        hit    = bus.data_valid && (fill_n == FULL) && (hist_n == PATTERN);
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = hit;
        if (bus.data_valid) begin
            hist_d = hist_n;
            fill_d = (hit && !bus.overlap_en) ? '0 : fill_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    assign bus.data_out = out_q;

`ifdef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // clear wins over a simultaneous hit; count sticks at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr)
            cnt_d = '0;
        else if (hit && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus.match_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param (PATTERN 1011): driver queues the hand-computed
// data_out (and match_cnt with SEQ_MATCH_CNT_EN) for each cycle; a monitor pops and compares.
module tb_seq_detect_param;
    localparam int unsigned CNT_W = 2;

    typedef struct {
        logic out;
        int   cnt;   // -1 = counter not checked
        int   tag;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   tag    = 0;

    seq_detect_param_if #(.CNT_W(CNT_W)) bus ();

    seq_detect_param #(
        .PAT_W  (4),
        .PATTERN(4'b1011),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle the DUT presents data_out; compare against queued expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_chk++;
            if (bus.data_out !== e.out) begin
                n_fail++;
                $display("FAIL data_out step %0d: got %b expected %b", e.tag, bus.data_out, e.out);
            end
`ifdef SEQ_MATCH_CNT_EN
            if (e.cnt >= 0) begin
                n_chk++;
                if (bus.match_cnt !== CNT_W'(e.cnt)) begin
                    n_fail++;
                    $display("FAIL match_cnt step %0d: got %0d expected %0d", e.tag, bus.match_cnt, e.cnt);
                end
            end
`endif
        end
    end

    task automatic step(input logic rst, input logic v, input logic d, input logic ov,
                        input logic clr, input logic eo, input int ec);
        exp_t e;
        @(negedge clk);
        reset          = rst;
        bus.data_valid = v;
        bus.data_in    = d;
        bus.overlap_en = ov;
`ifdef SEQ_MATCH_CNT_EN
        bus.cnt_clr    = clr;
`else
        if (clr) $display("note: cnt_clr requested without counter build");
`endif
        e.out = eo;
        e.cnt = ec;
        e.tag = tag++;
        sbq.push_back(e);
    endtask

    // accepted bit, no reset, no clear
    task automatic bit_in(input logic d, input logic ov, input logic eo);
        step(1'b0, 1'b1, d, ov, 1'b0, eo, -1);
    endtask

    task automatic rst_cycle();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.data_valid = 1'b0;
        bus.data_in    = 1'b0;
        bus.overlap_en = 1'b0;
`ifdef SEQ_MATCH_CNT_EN
        bus.cnt_clr    = 1'b0;
`endif
        // 1: reset for 2 cycles while feeding 1,0; then 1,1,0,0 must not match
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        bit_in(1, 1, 0); bit_in(1, 1, 0); bit_in(0, 1, 0); bit_in(0, 1, 0);

        // 2: overlap, 1011011 -> pulses after bits 4 and 7
        rst_cycle();
        bit_in(1, 1, 0); bit_in(0, 1, 0); bit_in(1, 1, 0); bit_in(1, 1, 1);
        bit_in(0, 1, 0); bit_in(1, 1, 0); bit_in(1, 1, 1);

        // 3: non-overlap, 1011011 -> pulse after bit 4 only; then 1011 -> pulse
        rst_cycle();
        bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 1);
        bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0);
        bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 1);

        // 4: gaps (data_in toggled while invalid) do not break 10..11
        rst_cycle();
        bit_in(1, 1, 0); bit_in(0, 1, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        bit_in(1, 1, 0); bit_in(1, 1, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);   // pulse lasts one cycle

        // 5: reset mid-pattern discards 1,0,1
        rst_cycle();
        bit_in(1, 1, 0); bit_in(0, 1, 0); bit_in(1, 1, 0);
        rst_cycle();
        bit_in(1, 1, 0); bit_in(0, 1, 0); bit_in(1, 1, 0); bit_in(1, 1, 1);

        // 6: counter saturation at 3 after 5 overlapping matches, clear beats 6th hit
        rst_cycle();
        step(0, 1, 1, 1, 0, 0, 0); step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 1, 1);
        step(0, 1, 0, 1, 0, 0, 1); step(0, 1, 1, 1, 0, 0, 1); step(0, 1, 1, 1, 0, 1, 2);
        step(0, 1, 0, 1, 0, 0, 2); step(0, 1, 1, 1, 0, 0, 2); step(0, 1, 1, 1, 0, 1, 3);
        step(0, 1, 0, 1, 0, 0, 3); step(0, 1, 1, 1, 0, 0, 3); step(0, 1, 1, 1, 0, 1, 3);
        step(0, 1, 0, 1, 0, 0, 3); step(0, 1, 1, 1, 0, 0, 3); step(0, 1, 1, 1, 0, 1, 3);
        step(0, 1, 0, 1, 0, 0, 3); step(0, 1, 1, 1, 0, 0, 3); step(0, 1, 1, 1, 1, 1, 0);
        step(0, 0, 0, 1, 0, 0, 0);

        // drain scoreboard with a bounded wait
        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
